// File: rtl/prog_counter.sv
// Programmable up/down counter with an enable-gated prescaler, selectable
// wrap / saturate / one-shot boundary behaviour and registered tc/done flags.
module prog_counter #(
   parameter int                 WIDTH          = 8,
   parameter int                 PRESCALE_WIDTH = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE    = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic                      dir,
   input  logic [1:0]                mode,
   input  logic [WIDTH-1:0]          min_value,
   input  logic [WIDTH-1:0]          max_value,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]          cnt,
   output logic                      tc,
   output logic                      done
);

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   state_t                    state_q;
   logic [WIDTH-1:0]          cnt_q;
   logic [PRESCALE_WIDTH-1:0] psc_q;
   logic                      tc_q;
   logic                      done_q;

   logic tick;
   logic at_bnd;

   assign tick   = enable && (psc_q == prescale);
   // Boundary is judged on the count before the tick is applied.
   assign at_bnd = dir ? (cnt_q >= max_value) : (cnt_q <= min_value);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= RESET_VALUE;
         psc_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         state_q <= RUN;
      end else if (load) begin
         cnt_q   <= load_value;
         psc_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         state_q <= RUN;
      end else if (!enable) begin
         tc_q <= 1'b0;
      end else if (!tick) begin
         // A prescale lowered below the running prescaler wraps around naturally.
         psc_q <= psc_q + PRESCALE_WIDTH'(1);
         tc_q  <= 1'b0;
      end else begin
         psc_q <= '0;
         tc_q  <= 1'b0;
         if (state_q == RUN) begin
            if (!at_bnd) begin
               cnt_q <= dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end else begin
               tc_q <= 1'b1;
               case (mode)
                  MODE_SAT: ;
                  MODE_ONESHOT: begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
                  default: cnt_q <= dir ? min_value : max_value;
               endcase
            end
         end
      end
   end

   assign cnt  = cnt_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios against fixed
// expectations plus a randomized run against a behavioural reference model.
module tb_prog_counter;

   localparam int         W  = 8;
   localparam int         PW = 8;
   localparam logic [7:0] RV = 8'h11;

   logic         clk = 1'b0;
   logic         reset, enable, load, dir;
   logic [7:0]   load_value, min_value, max_value, prescale;
   logic [1:0]   mode;
   logic [7:0]   cnt;
   logic         tc, done;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_cnt, m_psc;
   bit m_tc, m_done;

   prog_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .load_value(load_value), .dir(dir), .mode(mode),
      .min_value(min_value), .max_value(max_value), .prescale(prescale),
      .cnt(cnt), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt = RV; m_psc = 0; m_tc = 0; m_done = 0;
      end else if (load) begin
         m_cnt = load_value; m_psc = 0; m_tc = 0; m_done = 0;
      end else if (!enable) begin
         m_tc = 0;
      end else begin
         m_tc = 0;
         if (m_psc == int'(prescale)) begin
            m_psc = 0;
            if (!m_done) begin
               if (dir ? (m_cnt >= int'(max_value)) : (m_cnt <= int'(min_value))) begin
                  m_tc = 1;
                  if (mode == 2'b10) m_done = 1;
                  else if (mode != 2'b01) m_cnt = dir ? int'(min_value) : int'(max_value);
               end else begin
                  m_cnt = dir ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
               end
            end
         end else begin
            m_psc = (m_psc + 1) % 256;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_value = v;
      cyc();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b1; load_value = 8'hAA; enable = 1'b1;
      cyc(); cyc();
      checks++;
      if (cnt !== RV || tc !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset got cnt=%0d tc=%b done=%b exp cnt=%0d tc=0 done=0", cnt, tc, done, RV);
      end
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_wrap_up();
      logic [7:0] exp_c [8] = '{3, 4, 5, 2, 3, 4, 5, 2};
      logic       exp_t [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      min_value = 2; max_value = 5; prescale = 0; dir = 1; mode = 2'b00;
      do_load(8'd2);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if (cnt !== exp_c[i] || tc !== exp_t[i]) begin
            failures++;
            $display("FAIL wrap_up[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b", i, cnt, tc, exp_c[i], exp_t[i]);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_prescale_down();
      logic [7:0] exp_c [6] = '{1, 1, 0, 0, 0, 9};
      logic       exp_t [6] = '{0, 0, 0, 0, 0, 1};
      min_value = 0; max_value = 9; prescale = 2; dir = 0; mode = 2'b00;
      do_load(8'd1);
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (cnt !== exp_c[i] || tc !== exp_t[i]) begin
            failures++;
            $display("FAIL prescale_down[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b", i, cnt, tc, exp_c[i], exp_t[i]);
         end
      end
      // enable gaps stretch the spacing: two enabled cycles, a gap, then the tick
      enable = 1'b1; cyc(); cyc();
      enable = 1'b0; cyc(); cyc(); cyc();
      checks++;
      if (cnt !== 8'd9 || tc !== 1'b0) begin
         failures++;
         $display("FAIL prescale_hold got cnt=%0d tc=%b exp cnt=9 tc=0", cnt, tc);
      end
      enable = 1'b1; cyc();
      checks++;
      if (cnt !== 8'd8 || tc !== 1'b0) begin
         failures++;
         $display("FAIL prescale_gap_tick got cnt=%0d tc=%b exp cnt=8 tc=0", cnt, tc);
      end
      enable = 1'b0;
   endtask

   task automatic test_saturate();
      logic [7:0] exp_c [5] = '{199, 200, 200, 200, 200};
      logic       exp_t [5] = '{0, 0, 1, 1, 1};
      min_value = 0; max_value = 200; prescale = 0; dir = 1; mode = 2'b01;
      do_load(8'd198);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (cnt !== exp_c[i] || tc !== exp_t[i]) begin
            failures++;
            $display("FAIL saturate[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b", i, cnt, tc, exp_c[i], exp_t[i]);
         end
      end
      dir = 1'b0; cyc();
      checks++;
      if (cnt !== 8'd199 || tc !== 1'b0) begin
         failures++;
         $display("FAIL saturate_down got cnt=%0d tc=%b exp cnt=199 tc=0", cnt, tc);
      end
      enable = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [7:0] exp_c [6] = '{1, 2, 3, 3, 3, 3};
      logic       exp_t [6] = '{0, 0, 0, 1, 0, 0};
      logic       exp_d [6] = '{0, 0, 0, 1, 1, 1};
      min_value = 0; max_value = 3; prescale = 0; dir = 1; mode = 2'b10;
      do_load(8'd0);
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (cnt !== exp_c[i] || tc !== exp_t[i] || done !== exp_d[i]) begin
            failures++;
            $display("FAIL oneshot[%0d] got cnt=%0d tc=%b done=%b exp cnt=%0d tc=%b done=%b",
                     i, cnt, tc, done, exp_c[i], exp_t[i], exp_d[i]);
         end
      end
      // DONE ignores mode/dir changes
      mode = 2'b00; dir = 1'b0; cyc(); cyc();
      checks++;
      if (cnt !== 8'd3 || tc !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL oneshot_sticky got cnt=%0d tc=%b done=%b exp cnt=3 tc=0 done=1", cnt, tc, done);
      end
      mode = 2'b10; dir = 1'b1;
      do_load(8'd0);
      checks++;
      if (cnt !== 8'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL oneshot_reload got cnt=%0d done=%b exp cnt=0 done=0", cnt, done);
      end
      cyc();
      checks++;
      if (cnt !== 8'd1) begin
         failures++;
         $display("FAIL oneshot_resume got cnt=%0d exp 1", cnt);
      end
      enable = 1'b0;
   endtask

   task automatic test_collisions();
      // load and reset together
      reset = 1'b1; load = 1'b1; load_value = 8'h55; enable = 1'b1; cyc();
      reset = 1'b0; load = 1'b0; enable = 1'b0;
      checks++;
      if (cnt !== RV) begin
         failures++;
         $display("FAIL coll_reset_load got cnt=%0d exp %0d", cnt, RV);
      end
      // load on a cycle that would be a boundary tick in saturate mode
      min_value = 0; max_value = 50; prescale = 0; dir = 1; mode = 2'b01;
      do_load(8'd50);
      enable = 1'b1; cyc();
      load = 1'b1; load_value = 8'd7; cyc(); load = 1'b0;
      checks++;
      if (cnt !== 8'd7 || tc !== 1'b0) begin
         failures++;
         $display("FAIL coll_load_tick got cnt=%0d tc=%b exp cnt=7 tc=0", cnt, tc);
      end
      // reset while DONE
      mode = 2'b10; max_value = 8;
      cyc(); cyc();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL coll_reach_done got done=%b exp 1", done);
      end
      reset = 1'b1; cyc(); reset = 1'b0;
      checks++;
      if (done !== 1'b0 || cnt !== RV || tc !== 1'b0) begin
         failures++;
         $display("FAIL coll_reset_done got cnt=%0d tc=%b done=%b exp cnt=%0d tc=0 done=0", cnt, tc, done, RV);
      end
      // back in RUN: counting resumes from RESET_VALUE
      mode = 2'b00; max_value = 8'hF0; cyc();
      checks++;
      if (cnt !== RV + 8'd1) begin
         failures++;
         $display("FAIL coll_run_after_reset got cnt=%0d exp %0d", cnt, RV + 8'd1);
      end
      enable = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 59) == 0);
         load       = ($urandom_range(0, 11) == 0);
         load_value = 8'($urandom_range(0, 20));
         enable     = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0) dir  = 1'($urandom);
         if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            min_value = 8'($urandom_range(0, 8));
            max_value = 8'($urandom_range(4, 16));
         end
         if ($urandom_range(0, 29) == 0) prescale = 8'($urandom_range(0, 3));
         cyc();
         checks++;
         if (int'(cnt) !== m_cnt || tc !== m_tc || done !== m_done) begin
            failures++;
            $display("FAIL random[%0d] got cnt=%0d tc=%b done=%b exp cnt=%0d tc=%b done=%b",
                     i, cnt, tc, done, m_cnt, m_tc, m_done);
         end
      end
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; dir = 1'b1;
      mode = 2'b00; min_value = '0; max_value = 8'hFF; prescale = '0;
      test_reset();
      test_wrap_up();
      test_prescale_down();
      test_saturate();
      test_oneshot();
      test_collisions();
      // resynchronise the model's prescaler view before random traffic
      reset = 1'b1; cyc(); reset = 1'b0;
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter PRESCALE_WIDTH, default 8, width of the prescale divider field.
REQ-003 Parameter RESET_VALUE, default 0, value loaded into cnt on reset.
REQ-004 The interface SHALL be exactly as follows; clock clk; reset reset, synchronous, active-high.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- enable  input  1  count while high.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value taken on load.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- min_value  input  WIDTH  lower bound.
- max_value  input  WIDTH  upper bound.
- prescale  input  PRESCALE_WIDTH  tick every prescale+1 enabled cycles.
- cnt  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- done  output  1  one-shot complete flag.

Function
REQ-005 Priority SHALL be reset > load > enabled counting > hold.
REQ-006 Internal prescaler SHALL advance only on enabled cycles; a tick occurs on an enabled cycle where prescaler == prescale, and the prescaler then clears to 0; prescale = 0 gives a tick on every enabled cycle.
REQ-007 With enable low, cnt, prescaler and state SHALL hold and tc SHALL be 0.
REQ-008 Load SHALL set cnt = load_value, prescaler = 0, state = RUN, done = 0, tc = 0 on the next edge, regardless of enable.
REQ-009 Non-tick cycles SHALL hold cnt, and tc SHALL be 0.
REQ-010 Boundary SHALL be evaluated on the pre-tick cnt: up boundary is cnt >= max_value, down boundary is cnt <= min_value (unsigned compares).
REQ-011 On a tick off-boundary, cnt SHALL become cnt+1 (up) or cnt-1 (down), modulo 2^WIDTH.
REQ-012 On a tick at boundary, wrap mode: cnt SHALL become min_value (up) or max_value (down), and tc SHALL be 1 for one cycle.
REQ-013 On a tick at boundary, saturate mode: cnt SHALL hold, and tc SHALL be 1 on every such tick.
REQ-014 On a tick at boundary, one-shot mode: cnt SHALL hold, tc SHALL be 1 for one cycle, state SHALL go RUN -> DONE, and done SHALL go to 1.
REQ-015 State machine SHALL have two states, RUN and DONE; DONE is exited only by load or reset; in DONE, ticks SHALL not change cnt and tc SHALL stay 0, independent of mode or dir changes.
REQ-016 Changes to mode, dir, min_value, max_value or prescale SHALL take effect on the next tick with no restart; if the new prescale is below the current prescaler value, the next tick occurs after prescaler wraps at 2^PRESCALE_WIDTH.
REQ-017 min_value > max_value SHALL not be trapped; behaviour follows REQ-010..REQ-014 literally.
REQ-018 tc and done SHALL be registered with no combinational path from inputs.

Reset
REQ-019 Reset SHALL set cnt = RESET_VALUE, prescaler = 0, tc = 0, done = 0, state = RUN on the next edge, overriding load and enable, including mid-count and in DONE.

Verification
REQ-020 Wrap up: WIDTH=8, min=2, max=5, prescale=0, dir=1, mode=00, load 2, enable -> cnt 3,4,5,2,3…, with tc=1 only in the cycle cnt shows 2 after 5.
REQ-021 Prescale down: prescale=2, dir=0, mode=00, min=0, max=9, load 1 -> cnt changes every 3rd enabled cycle: 1 -> 0 -> 9, with tc pulse at 9; toggling enable low stretches spacing accordingly.
REQ-022 Saturate: mode=01, max=200, load 198, up -> cnt 199, 200, 200…, with tc=1 on each tick while at 200; then dir=0 -> cnt 199 on next tick.
REQ-023 One-shot: mode=10, max=3, load 0 -> cnt 1,2,3, done=1 with a single tc pulse, cnt stays 3; load 0 -> done=0 and counting resumes.
REQ-024 Collisions: load and reset together -> cnt=RESET_VALUE; load during a tick cycle -> cnt=load_value, tc=0; reset while DONE -> done=0, state RUN.
